// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion, wall/paddle bounces, miss detection and scoring for the pong field
module pong_ball_ctrl #(
   parameter int XSCREEN     = 160,
   parameter int YSCREEN     = 120,
   parameter int SIZE        = 5,
   parameter int X_START     = 78,
   parameter int Y_START     = 58,
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 60
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       tick,
   input  logic       start,
   input  logic       player1,
   input  logic       player2,
   output logic [7:0] X,
   output logic [6:0] Y,
   output logic       dx,
   output logic       dy,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       point,
   output logic       game_over,
   output logic [1:0] state
);
   typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER, S_POINT} state_t;
   localparam logic [7:0] X_MAX = 8'(XSCREEN - SIZE);
   localparam logic [7:0] X_CTR = 8'(X_START);
   localparam logic [6:0] Y_MAX = 7'(YSCREEN - SIZE);
   localparam logic [6:0] Y_CTR = 7'(Y_START);
   localparam logic [3:0] WIN   = 4'(WIN_SCORE);
   localparam logic [7:0] DELAY = 8'(SERVE_DELAY);
   state_t     r_state, w_state;
   logic       r_tick_prev, r_hit1, r_hit2, r_dx, r_dy, r_point;
   logic [7:0] r_cnt, r_x;
   logic [6:0] r_y;
   logic [3:0] r_s1, r_s2;
   logic       w_step, w_hit1, w_hit2, w_pdx, w_dx, w_dy, w_point;
   logic [7:0] w_cnt, w_x;
   logic [6:0] w_y;
   logic [3:0] w_s1, w_s2, w_old, w_new;
   assign w_step = tick & ~r_tick_prev;
   assign w_hit1 = r_hit1 | player1;
   assign w_hit2 = r_hit2 | player2;
   assign w_pdx  = (w_hit1 & ~w_hit2) ? 1'b1 : (w_hit2 & ~w_hit1) ? 1'b0 : r_dx;
   // in POINT the stored dx still names the edge that was missed, hence the scorer
   assign w_old  = r_dx ? r_s1 : r_s2;
   assign w_new  = (w_old == WIN) ? w_old : w_old + 4'd1;
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_x     = r_x;
      w_y     = r_y;
      w_dx    = r_dx;
      w_dy    = r_dy;
      w_s1    = r_s1;
      w_s2    = r_s2;
      w_point = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_state = S_SERVE;
            w_cnt   = DELAY;
         end
         S_SERVE: if (w_step) begin
            if (r_cnt == 8'd0) w_state = S_PLAY;
            else w_cnt = r_cnt - 8'd1;
         end
         S_PLAY: if (w_step) begin
            w_dx = w_pdx;
            w_dy = (r_dy && r_y == Y_MAX) ? 1'b0 : (!r_dy && r_y == 7'd0) ? 1'b1 : r_dy;
            w_y  = w_dy ? r_y + 7'd1 : r_y - 7'd1;
            if ((!w_pdx && r_x == 8'd0) || (w_pdx && r_x == X_MAX)) w_state = S_POINT;
            else w_x = w_pdx ? r_x + 8'd1 : r_x - 8'd1;
         end
         S_POINT: begin
            w_point = 1'b1;
            w_x     = X_CTR;
            w_y     = Y_CTR;
            w_cnt   = DELAY;
            if (r_dx) w_s1 = w_new;
            else w_s2 = w_new;
            w_state = (w_new == WIN) ? S_OVER : S_SERVE;
         end
         S_OVER: if (start) begin
            w_s1    = 4'd0;
            w_s2    = 4'd0;
            w_dx    = 1'b1;
            w_dy    = 1'b1;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state     <= S_IDLE;
         r_tick_prev <= 1'b0;
         r_hit1      <= 1'b0;
         r_hit2      <= 1'b0;
         r_cnt       <= 8'd0;
         r_x         <= X_CTR;
         r_y         <= Y_CTR;
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_s1        <= 4'd0;
         r_s2        <= 4'd0;
         r_point     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_tick_prev <= tick;
         r_hit1      <= w_step ? 1'b0 : w_hit1;
         r_hit2      <= w_step ? 1'b0 : w_hit2;
         r_cnt       <= w_cnt;
         r_x         <= w_x;
         r_y         <= w_y;
         r_dx        <= w_dx;
         r_dy        <= w_dy;
         r_s1        <= w_s1;
         r_s2        <= w_s2;
         r_point     <= w_point;
      end
   end
   assign X         = r_x;
   assign Y         = r_y;
   assign dx        = r_dx;
   assign dy        = r_dy;
   assign score1    = r_s1;
   assign score2    = r_s2;
   assign point     = r_point;
   assign game_over = (r_state == S_OVER);
   assign state     = (r_state == S_POINT) ? 2'd2 : r_state[1:0];
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed step vectors plus hand-written miss, tick-hold and reset sequences
module tb_pong_ball_ctrl;
   logic       Clock = 1'b0, Resetn = 1'b0, tick = 1'b0, start = 1'b0, player1 = 1'b0, player2 = 1'b0;
   logic [7:0] X;
   logic [6:0] Y;
   logic       dx, dy, point, game_over;
   logic [3:0] score1, score2;
   logic [1:0] state;
   int         total = 0, bad = 0;
   typedef struct {int st, p1, p2, n, x, y, dx, dy, s, s1, s2, go;} vec_t;
   vec_t       tbl[$];
   always #5 Clock = ~Clock;
   pong_ball_ctrl #(.SERVE_DELAY(3), .WIN_SCORE(2)) dut (
      .Clock(Clock), .Resetn(Resetn), .tick(tick), .start(start),
      .player1(player1), .player2(player2), .X(X), .Y(Y), .dx(dx), .dy(dy),
      .score1(score1), .score2(score2), .point(point), .game_over(game_over), .state(state)
   );
   task automatic chk(string n, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask
   task automatic check_all(string p, int x, int y, int ddx, int ddy, int s, int s1, int s2, int go, int pt);
      chk({p, ".X"}, int'(X), x);
      chk({p, ".Y"}, int'(Y), y);
      chk({p, ".dx"}, int'(dx), ddx);
      chk({p, ".dy"}, int'(dy), ddy);
      chk({p, ".state"}, int'(state), s);
      chk({p, ".score1"}, int'(score1), s1);
      chk({p, ".score2"}, int'(score2), s2);
      chk({p, ".game_over"}, int'(game_over), go);
      chk({p, ".point"}, int'(point), pt);
   endtask
   task automatic add(int st, int p1, int p2, int n, int x, int y, int ddx, int ddy, int s, int s1, int s2, int go);
      tbl.push_back('{st, p1, p2, n, x, y, ddx, ddy, s, s1, s2, go});
   endtask
   // one frame step; the extra settle cycle lets a POINT pulse come and go
   task automatic step();
      @(negedge Clock) tick = 1'b1;
      @(negedge Clock) tick = 1'b0;
      repeat (2) @(negedge Clock);
   endtask
   task automatic apply(int i);
      vec_t v;
      v = tbl[i];
      if (v.st != 0) begin
         @(negedge Clock) start = 1'b1;
         @(negedge Clock) start = 1'b0;
      end
      if (v.p1 != 0 || v.p2 != 0) begin
         @(negedge Clock);
         player1 = (v.p1 != 0);
         player2 = (v.p2 != 0);
         @(negedge Clock);
         player1 = 1'b0;
         player2 = 1'b0;
      end
      repeat (v.n) step();
      check_all($sformatf("v%0d", i), v.x, v.y, v.dx, v.dy, v.s, v.s1, v.s2, v.go, 0);
   endtask
   initial begin
      int np;
      //  st p1 p2   n    x    y dx dy  s s1 s2 go
      add(0, 0, 0,   1,  78,  58, 1, 1, 0, 0, 0, 0);
      add(1, 0, 0,   0,  78,  58, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0,   3,  78,  58, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0,   1,  78,  58, 1, 1, 2, 0, 0, 0);
      add(0, 0, 0,   1,  79,  59, 1, 1, 2, 0, 0, 0);
      add(0, 0, 0,  56, 135, 115, 1, 1, 2, 0, 0, 0);
      add(0, 0, 0,   1, 136, 114, 1, 0, 2, 0, 0, 0);
      add(0, 0, 1,   1, 135, 113, 0, 0, 2, 0, 0, 0);
      add(0, 1, 0,   1, 136, 112, 1, 0, 2, 0, 0, 0);
      add(0, 1, 1,   1, 137, 111, 1, 0, 2, 0, 0, 0);
      add(0, 0, 1,   1, 136, 110, 0, 0, 2, 0, 0, 0);
      add(0, 0, 0, 110,  26,   0, 0, 0, 2, 0, 0, 0);
      add(0, 0, 0,   1,  25,   1, 0, 1, 2, 0, 0, 0);
      add(0, 0, 0,  25,   0,  26, 0, 1, 2, 0, 0, 0);
      add(0, 0, 0,   4,  78,  58, 0, 1, 2, 0, 1, 0);
      add(0, 1, 0,   1,  79,  59, 1, 1, 2, 0, 1, 0);
      add(0, 0, 0,  76, 155,  95, 1, 0, 2, 0, 1, 0);
      add(0, 0, 0,   1,  78,  58, 1, 0, 1, 1, 1, 0);
      add(0, 0, 0,   4,  78,  58, 1, 0, 2, 1, 1, 0);
      add(0, 0, 0,  77, 155,  19, 1, 1, 2, 1, 1, 0);
      add(0, 0, 0,   1,  78,  58, 1, 1, 3, 2, 1, 1);
      add(0, 0, 0,   3,  78,  58, 1, 1, 3, 2, 1, 1);
      add(1, 0, 0,   0,  78,  58, 1, 1, 0, 0, 0, 0);
      add(1, 0, 0,   0,  78,  58, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0,   4,  78,  58, 1, 1, 2, 0, 0, 0);
      repeat (2) @(negedge Clock);
      check_all("reset", 78, 58, 1, 1, 0, 0, 0, 0, 0);
      Resetn = 1'b1;
      for (int i = 0; i < 14; i++) apply(i);
      // left miss: POINT reports as PLAY for one cycle, then a single point pulse
      np = 0;
      @(negedge Clock) tick = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clock);
         tick = 1'b0;
         if (k == 0) chk("point_state_play", int'(state), 2);
         if (point) begin
            np++;
            if (np == 1) check_all("miss_left", 78, 58, 0, 1, 1, 0, 1, 0, 1);
         end
      end
      chk("point_pulse_len", np, 1);
      for (int i = 14; i < tbl.size(); i++) apply(i);
      @(negedge Clock) tick = 1'b1;
      repeat (100) @(negedge Clock);
      tick = 1'b0;
      repeat (2) @(negedge Clock);
      chk("tick_hold.X", int'(X), 79);
      chk("tick_hold.Y", int'(Y), 59);
      @(negedge Clock) Resetn = 1'b0;
      @(negedge Clock);
      check_all("mid_reset", 78, 58, 1, 1, 0, 0, 0, 0, 0);
      Resetn = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
